ctrl_filtro_200: RTL and testbench
==================================

CTRL_FILTRO_200 -- requirements
Module: ctrl_filtro_200

Interface
REQ-001 The block SHALL expose parameter N_TERMS, default 6, number of multiply-accumulate terms per sample.
REQ-002 The block SHALL expose parameter SEL_W, default 4, width of the coefficient/input select bus.
REQ-003 The block SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 The block SHALL have port rst  input  1  synchronous, active-low reset.
REQ-005 The block SHALL have port start  input  1  new-sample strobe from the upstream receiver; one-cycle pulse.
REQ-006 The block SHALL have port clr_ovr  input  1  clears the sticky overrun flag.
REQ-007 The block SHALL have port sel  output  SEL_W  term index to the filter's coefficient and input muxes.
REQ-008 The block SHALL have port rst_acum  output  1  accumulator clear to the filter datapath.
REQ-009 The block SHALL have port leer  output  1  write of the rounded result into the state memory.
REQ-010 The block SHALL have port desp  output  1  shift of the state memory (f -> f1 -> f2).
REQ-011 The block SHALL have port leer_y  output  1  load of the rounded result into the output register.
REQ-012 The block SHALL have port busy  output  1  sequence in progress.
REQ-013 The block SHALL have port done  output  1  one-cycle pulse; filtered sample valid.
REQ-014 The block SHALL have port overrun  output  1  sticky flag: start arrived while busy.

Function
REQ-015 All outputs SHALL be registered; no combinational path from start to any output.
REQ-016 The FSM SHALL have states IDLE, CLR, MAC, STORE, SHIFT, OUT, DONE.
REQ-017 Only IDLE SHALL accept start; IDLE -> CLR on the edge where start=1.
REQ-018 CLR SHALL last 1 cycle with rst_acum=1; then -> MAC.
REQ-019 MAC SHALL last exactly N_TERMS cycles with sel = 0, 1, ..., N_TERMS-1 on consecutive cycles, via an internal term counter; then -> STORE.
REQ-020 STORE SHALL last 1 cycle with leer=1; SHIFT 1 cycle with desp=1; OUT 1 cycle with leer_y=1; DONE 1 cycle with done=1; DONE -> IDLE.
REQ-021 sel SHALL equal 0 outside MAC; rst_acum, leer, desp, leer_y, done SHALL each be 1 only in their own state and never two at once.
REQ-022 busy SHALL be 1 in CLR through DONE inclusive and 0 in IDLE.
REQ-023 Latency: with start sampled at edge 0, rst_acum=1 in cycle 1, sel=0..5 in cycles 2..7, leer in 8, desp in 9, leer_y in 10, done in 11, IDLE at cycle 12 (N_TERMS=6).
REQ-024 Back-to-back: start in the cycle after DONE SHALL be accepted; minimum sample spacing is N_TERMS+6 cycles.
REQ-025 start while busy=1 (including in DONE) SHALL NOT restart or perturb the running sequence.
REQ-026 Term counter SHALL be width SEL_W and SHALL never exceed N_TERMS-1; no wrap-around into a seventh term.
REQ-027 N_TERMS SHALL satisfy 1 <= N_TERMS <= 2^SEL_W.

Reset
REQ-028 rst=0 at a rising edge SHALL force IDLE, term counter 0, sel=0, and rst_acum, leer, desp, leer_y, busy, done, overrun all 0 on the following cycle.
REQ-029 Reset mid-sequence SHALL abort with no further leer, desp or leer_y pulse; start coincident with rst=0 SHALL be ignored.
REQ-030 The first start accepted after reset release SHALL be one sampled while rst=1.

Configuration
REQ-031 Macro OVERRUN_DETECT_EN defined: overrun SHALL be set on any edge with start=1 and busy=1, held until clr_ovr=1 or reset; set has priority over clr_ovr in the same cycle.
REQ-032 Macro OVERRUN_DETECT_EN undefined: overrun SHALL be constant 0, clr_ovr ignored, the dropped-start behaviour of REQ-025 unchanged.

Verification
REQ-033 Reset, single start pulse -> rst_acum at cycle 1, sel 0..5 at cycles 2..7, leer 8, desp 9, leer_y 10, done 11, busy high cycles 1..11.
REQ-034 start at cycles 0 and 12 -> two complete identical sequences, done at 11 and 23, overrun=0.
REQ-035 start at cycles 0 and 5 (OVERRUN_DETECT_EN) -> single sequence unchanged, overrun=1 from cycle 6 until clr_ovr pulse; without macro overrun stays 0.
REQ-036 rst=0 at cycle 6 (in MAC) -> all outputs 0 at cycle 7, no leer/desp/leer_y pulse; new start at cycle 10 -> full sequence.
REQ-037 N_TERMS=3 -> sel 0,1,2 then leer at cycle 5, done at cycle 8.
REQ-038 start and clr_ovr together while busy (OVERRUN_DETECT_EN) -> overrun=1 next cycle.

Source files
------------

// File: rtl/ctrl_filtro_200_if.sv
// ctrl_filtro_200_if: handshake and datapath-control bundle of the filter sequencer.
// master: the sequencer (drives term select and strobes, receives start/clear).
// slave:  the surrounding receiver/datapath side.
interface ctrl_filtro_200_if #(
  parameter int unsigned SEL_W = 4
) ();

  logic             start;
  logic             clr_ovr;
  logic [SEL_W-1:0] sel;
  logic             rst_acum;
  logic             leer;
  logic             desp;
  logic             leer_y;
  logic             busy;
  logic             done;
  logic             overrun;

  modport master (
    input  start,
    input  clr_ovr,
    output sel,
    output rst_acum,
    output leer,
    output desp,
    output leer_y,
    output busy,
    output done,
    output overrun
  );

  modport slave (
    output start,
    output clr_ovr,
    input  sel,
    input  rst_acum,
    input  leer,
    input  desp,
    input  leer_y,
    input  busy,
    input  done,
    input  overrun
  );

endinterface

// File: rtl/ctrl_filtro_200.sv
// ctrl_filtro_200: sequencer for a multiply-accumulate filter datapath.
// Per accepted start: clear accumulator, N_TERMS MAC cycles with sel = 0..N_TERMS-1,
// store result, shift state memory, load output register, pulse done.
// All outputs are registered (decoded from the next state), so start never reaches an
// output combinationally.
// Optional feature: define OVERRUN_DETECT_EN to enable the sticky overrun flag
// (set by start while busy, cleared by clr_ovr, set wins). Undefined: overrun tied to 0.
// Legal range: 1 <= N_TERMS <= 2**SEL_W.
module ctrl_filtro_200 #(
  parameter int unsigned N_TERMS = 6,
  parameter int unsigned SEL_W   = 4
) (
  input logic                clk,
  input logic                rst,
  ctrl_filtro_200_if.master  bus
);

  typedef enum logic [2:0] {
    StIdle,
    StClr,
    StMac,
    StStore,
    StShift,
    StOut,
    StDone
  } state_e;

  localparam logic [SEL_W-1:0] LastTerm = SEL_W'(N_TERMS - 1);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] cnt_q, cnt_d;

  logic [SEL_W-1:0] sel_q, sel_d;
  logic             rst_acum_q, rst_acum_d;
  logic             leer_q, leer_d;
  logic             desp_q, desp_d;
  logic             leer_y_q, leer_y_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // State and term counter register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and term counter; start is only looked at in idle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (bus.start) begin
          state_d = StClr;
        end
      end
      StClr: begin
        cnt_d   = '0;
        state_d = StMac;
      end
      StMac: begin
        // >= rather than == so a corrupted counter can never run past the last term
        if (cnt_q >= LastTerm) begin
          cnt_d   = '0;
          state_d = StStore;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StStore: state_d = StShift;
      StShift: state_d = StOut;
      StOut:   state_d = StDone;
      StDone:  state_d = StIdle;
      default: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
    endcase
  end

  // Output decode from the next state so the registered outputs line up with the state
  always_comb begin
    sel_d      = '0;
    rst_acum_d = 1'b0;
    leer_d     = 1'b0;
    desp_d     = 1'b0;
    leer_y_d   = 1'b0;
    done_d     = 1'b0;
    busy_d     = (state_d != StIdle);
    unique case (state_d)
      StClr:   rst_acum_d = 1'b1;
      StMac:   sel_d      = cnt_d;
      StStore: leer_d     = 1'b1;
      StShift: desp_d     = 1'b1;
      StOut:   leer_y_d   = 1'b1;
      StDone:  done_d     = 1'b1;
      default: ;
    endcase
  end

  // Output register
  always_ff @(posedge clk) begin
    if (!rst) begin
      sel_q      <= '0;
      rst_acum_q <= 1'b0;
      leer_q     <= 1'b0;
      desp_q     <= 1'b0;
      leer_y_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      sel_q      <= sel_d;
      rst_acum_q <= rst_acum_d;
      leer_q     <= leer_d;
      desp_q     <= desp_d;
      leer_y_q   <= leer_y_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.sel      = sel_q;
  assign bus.rst_acum = rst_acum_q;
  assign bus.leer     = leer_q;
  assign bus.desp     = desp_q;
  assign bus.leer_y   = leer_y_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

`ifdef OVERRUN_DETECT_EN
  logic overrun_q, overrun_d;

  // Sticky overrun: a start seen while busy sets it, set wins over a same-cycle clear
  always_comb begin
    overrun_d = overrun_q;
    if (bus.start && busy_q) begin
      overrun_d = 1'b1;
    end else if (bus.clr_ovr) begin
      overrun_d = 1'b0;
    end
  end

  // Overrun flag register
  always_ff @(posedge clk) begin
    if (!rst) begin
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= overrun_d;
    end
  end

  assign bus.overrun = overrun_q;
`else
  logic unused_clr_ovr;
  assign unused_clr_ovr = bus.clr_ovr;
  assign bus.overrun    = 1'b0;
`endif

`ifndef SYNTHESIS
  // Datapath strobes are mutually exclusive
  strobes_onehot0: assert property (@(posedge clk) disable iff (!rst)
    $onehot0({rst_acum_q, leer_q, desp_q, leer_y_q, done_q}));

  // Term select never exceeds the last term
  sel_in_range: assert property (@(posedge clk) disable iff (!rst)
    sel_q <= LastTerm);

  // Select is parked at zero while idle
  sel_zero_idle: assert property (@(posedge clk) disable iff (!rst)
    !busy_q |-> sel_q == '0);
`endif

endmodule

// File: tb/tb_ctrl_filtro_200.sv
// tb_ctrl_filtro_200: directed bench for the filter sequencer (N_TERMS=6 and N_TERMS=3).
// Cycle numbering: start is held during cycle 0, sampled at the edge ending it;
// cycle k is the period after the k-th such edge.
module tb_ctrl_filtro_200;

  localparam int unsigned SelW = 4;
`ifdef OVERRUN_DETECT_EN
  localparam logic OvrEn = 1'b1;
`else
  localparam logic OvrEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ctrl_filtro_200_if #(.SEL_W(SelW)) bus6 ();
  ctrl_filtro_200_if #(.SEL_W(SelW)) bus3 ();

  ctrl_filtro_200 #(.N_TERMS(6), .SEL_W(SelW)) dut6 (
    .clk (clk),
    .rst (rst),
    .bus (bus6.master)
  );

  ctrl_filtro_200 #(.N_TERMS(3), .SEL_W(SelW)) dut3 (
    .clk (clk),
    .rst (rst),
    .bus (bus3.master)
  );

  logic [5:0] obs6, obs3;
  assign obs6 = {bus6.busy, bus6.rst_acum, bus6.leer, bus6.desp, bus6.leer_y, bus6.done};
  assign obs3 = {bus3.busy, bus3.rst_acum, bus3.leer, bus3.desp, bus3.leer_y, bus3.done};

  int   n_checks = 0;
  int   n_errs   = 0;
  logic ovr_exp;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // c = cycle within a sequence (0 = idle); n = number of terms
  task automatic chk(input string tag, input int c, input int n, input logic [5:0] obs,
                     input logic [SelW-1:0] sel_obs, input logic ovr_obs, input logic ovr_e);
    logic [5:0]      ev;
    logic [SelW-1:0] es;
    ev = '0;
    es = '0;
    if (c >= 1 && c <= n + 5) ev[5] = 1'b1;
    if (c == 1)               ev[4] = 1'b1;
    if (c == n + 2)           ev[3] = 1'b1;
    if (c == n + 3)           ev[2] = 1'b1;
    if (c == n + 4)           ev[1] = 1'b1;
    if (c == n + 5)           ev[0] = 1'b1;
    if (c >= 2 && c <= n + 1) es = SelW'(c - 2);
    n_checks++;
    assert (obs === ev) else begin
      n_errs++;
      $error("FAIL %s cyc=%0d strobes(busy,rst_acum,leer,desp,leer_y,done) got=%b exp=%b",
             tag, c, obs, ev);
    end
    n_checks++;
    assert (sel_obs === es) else begin
      n_errs++;
      $error("FAIL %s cyc=%0d sel got=%0d exp=%0d", tag, c, sel_obs, es);
    end
    n_checks++;
    assert (ovr_obs === ovr_e) else begin
      n_errs++;
      $error("FAIL %s cyc=%0d overrun got=%b exp=%b", tag, c, ovr_obs, ovr_e);
    end
  endtask

  task automatic c6(input string tag, input int c);
    chk(tag, c, 6, obs6, bus6.sel, bus6.overrun, ovr_exp);
  endtask

  task automatic c3(input string tag, input int c);
    chk(tag, c, 3, obs3, bus3.sel, bus3.overrun, 1'b0);
  endtask

  initial begin
    rst          = 1'b0;
    bus6.start   = 1'b0;
    bus6.clr_ovr = 1'b0;
    bus3.start   = 1'b0;
    bus3.clr_ovr = 1'b0;
    ovr_exp      = 1'b0;

    // Reset, with a start held during reset that must be ignored
    tick();
    tick();
    bus6.start = 1'b1;
    tick();
    bus6.start = 1'b0;
    c6("reset", 0);
    c3("reset", 0);
    rst = 1'b1;
    tick();
    c6("idle_after_reset", 0);

    // Single sequence followed by a back-to-back start in cycle 12
    bus6.start = 1'b1;
    tick();
    bus6.start = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      c6("single", c);
      tick();
    end
    c6("single_idle", 0);
    bus6.start = 1'b1;
    tick();
    bus6.start = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      c6("b2b", c);
      tick();
    end
    c6("b2b_idle", 0);

    // Starts while busy (cycle 5 in MAC, cycle 11 in DONE) are dropped
    bus6.start = 1'b1;
    tick();
    bus6.start = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      c6("drop", c);
      if (c == 5 || c == 11) bus6.start = 1'b1;
      tick();
      bus6.start = 1'b0;
      if (c == 5) ovr_exp = OvrEn;
    end
    c6("drop_idle", 0);
    tick();
    c6("drop_idle2", 0);

    // Set and clear together while busy: set wins; later clear alone clears
    bus6.start = 1'b1;
    tick();
    bus6.start = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      c6("prio", c);
      if (c == 3) begin
        bus6.start   = 1'b1;
        bus6.clr_ovr = 1'b1;
      end
      if (c == 5) bus6.clr_ovr = 1'b1;
      tick();
      bus6.start   = 1'b0;
      bus6.clr_ovr = 1'b0;
      if (c == 5) ovr_exp = 1'b0;
    end
    c6("prio_idle", 0);

    // Reset in MAC at cycle 6 (start coincident with reset ignored), restart at cycle 10
    bus6.start = 1'b1;
    tick();
    bus6.start = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      c6("abort", c);
      if (c < 6) tick();
    end
    rst        = 1'b0;
    bus6.start = 1'b1;
    tick();
    rst        = 1'b1;
    bus6.start = 1'b0;
    for (int c = 7; c <= 10; c++) begin
      c6("abort_quiet", 0);
      if (c < 10) tick();
    end
    bus6.start = 1'b1;
    tick();
    bus6.start = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      c6("restart", c);
      tick();
    end

    // Three-term instance: leer at 5, done at 8, idle at 9
    bus3.start = 1'b1;
    tick();
    bus3.start = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      c3("n3", c);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
